xpb_table_gen: RTL and testbench

- Runtime generator for xpb reduction tables: computes entry k = (k * 2^OFFSET) mod N for k = 0 .. 2^IDX_BITS-1.
- Streams the entries into a RAM-backed xpb table through a valid/ready write port.
- Sits between host modulus/configuration load and the modular-square reduction tree, so that a new modulus does not require regenerating hard-coded constant tables.

---
 rtl/xpb_table_gen_pkg.sv | 17 +
 rtl/xpb_table_gen_if.sv | 21 ++
 rtl/xpb_table_gen_mod_add_reduce.sv | 23 ++
 rtl/xpb_table_gen.sv | 139 +++++++++++++
 tb/tb_xpb_table_gen.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xpb_table_gen_pkg.sv
// Shared types and default sizes for the xpb table generator.
//   - xpb_state_e : generator FSM states
//   - XPB_*       : default modulus width, index width, offset width
package xpb_table_gen_pkg;

  localparam int unsigned XPB_WIDTH      = 1024;
  localparam int unsigned XPB_IDX_BITS   = 5;
  localparam int unsigned XPB_SHIFT_BITS = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POW  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } xpb_state_e;

endpackage

// File: rtl/xpb_table_gen_if.sv
// Write port from the table generator into the RAM-backed xpb table.
//   wr_valid/wr_ready : handshake (entry moves when both are high)
//   wr_addr           : table index k
//   wr_data           : table entry, always < N
//   master : generator side, slave : table RAM side
interface xpb_table_gen_if
  import xpb_table_gen_pkg::*;
#(
  parameter int unsigned WIDTH    = XPB_WIDTH,
  parameter int unsigned IDX_BITS = XPB_IDX_BITS
) ();

  logic                wr_valid;
  logic                wr_ready;
  logic [IDX_BITS-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/xpb_table_gen_mod_add_reduce.sv
// Combinational (a + b) mod n for operands already reduced below n.
//   a, b  : addends, each < n
//   n     : modulus
//   sum_c : reduced sum, WIDTH bits
module mod_add_reduce #(
  parameter int unsigned WIDTH = 1024
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] sum_c
);

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] n_w;

  assign sum_w = {1'b0, a} + {1'b0, b};
  assign n_w   = {1'b0, n};

  // Both operands are < n, so one conditional subtract fully reduces the sum.
  assign sum_c = WIDTH'((sum_w >= n_w) ? (sum_w - n_w) : sum_w);

endmodule

// File: rtl/xpb_table_gen.sv
// Runtime xpb table generator: writes entry k = (k * 2^offset) mod N for
// k = 0 .. 2^IDX_BITS-1 into the table RAM through a valid/ready port.
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin generation (sampled only in IDLE)
//   modulus    : N, latched on accepted start
//   offset     : table bit position, latched on accepted start
//   busy       : generation in progress
//   done       : one-cycle pulse after the last entry is accepted
//   err        : (XPB_TABLE_GEN_RANGE_CHECK_EN only) last start had N < 2 or even N
//   wr         : table write port (master side)
// Optional build macro: XPB_TABLE_GEN_RANGE_CHECK_EN.
module xpb_table_gen
  import xpb_table_gen_pkg::*;
#(
  parameter int unsigned WIDTH      = XPB_WIDTH,
  parameter int unsigned IDX_BITS   = XPB_IDX_BITS,
  parameter int unsigned SHIFT_BITS = XPB_SHIFT_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [SHIFT_BITS-1:0] offset,
  output logic                  busy,
  output logic                  done,
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
  output logic                  err,
`endif
  xpb_table_gen_if.master       wr
);

  xpb_state_e            state;
  logic [WIDTH-1:0]      n_q;
  logic [WIDTH-1:0]      base;
  logic [WIDTH-1:0]      acc;
  logic [SHIFT_BITS-1:0] cnt;
  logic [IDX_BITS-1:0]   k;
  logic                  valid_q;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_sum;

  // One shared reducer: doubling of base in POW, accumulate acc+base in EMIT.
  always_comb begin
    add_a = base;
    if (state == EMIT) begin
      add_a = acc;
    end
  end

  mod_add_reduce #(.WIDTH(WIDTH)) u_add (
    .a     (add_a),
    .b     (base),
    .n     (n_q),
    .sum_c (add_sum)
  );

  assign wr.wr_valid = valid_q;
  assign wr.wr_addr  = k;
  assign wr.wr_data  = acc;

  // Generator FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      n_q     <= '0;
      base    <= '0;
      acc     <= '0;
      cnt     <= '0;
      k       <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q  <= modulus;
            cnt  <= offset;
            base <= (modulus > WIDTH'(1)) ? WIDTH'(1) : '0;
            acc  <= '0;
            k    <= '0;
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
            if ((modulus < WIDTH'(2)) || !modulus[0]) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= POW;
            end
`else
            busy  <= 1'b1;
            state <= POW;
`endif
          end
        end
        POW: begin
          // cnt==0 on entry means no doubling; otherwise the last doubling
          // happens together with the exit, so POW spans max(offset,1) cycles.
          if (cnt != '0) begin
            base <= add_sum;
            cnt  <= cnt - SHIFT_BITS'(1);
          end
          if (cnt <= SHIFT_BITS'(1)) begin
            acc     <= '0;
            k       <= '0;
            valid_q <= 1'b1;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (wr.wr_ready) begin
            if (k == '1) begin
              valid_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              acc <= add_sum;
              k   <= k + IDX_BITS'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Self-checking bench for xpb_table_gen: a 16-bit instance for the directed
// small-modulus cases and a 1024-bit instance for the wide random modulus.
// Expected writes are queued per run; a negedge monitor pops and compares.
module tb_xpb_table_gen;

  localparam int unsigned SW = 16;
  localparam int unsigned BW = 1024;
  localparam int unsigned IB = 5;
  localparam int unsigned SB = 11;
  localparam int unsigned MW = 2112;

  typedef struct packed {
    logic [IB-1:0] addr;
    logic [BW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          rdy;
  logic          sel;
  logic          start_s, start_b;
  logic [SW-1:0] mod_s;
  logic [BW-1:0] mod_b;
  logic [SB-1:0] off_s, off_b;
  logic          busy_s, done_s, busy_b, done_b;
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
  logic          err_s, err_b;
`endif

  xpb_table_gen_if #(.WIDTH(SW), .IDX_BITS(IB)) ifs ();
  xpb_table_gen_if #(.WIDTH(BW), .IDX_BITS(IB)) ifb ();

  assign ifs.wr_ready = rdy;
  assign ifb.wr_ready = rdy;

  xpb_table_gen #(.WIDTH(SW), .IDX_BITS(IB), .SHIFT_BITS(SB)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .modulus(mod_s), .offset(off_s),
    .busy(busy_s), .done(done_s),
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
    .err(err_s),
`endif
    .wr(ifs.master)
  );

  xpb_table_gen #(.WIDTH(BW), .IDX_BITS(IB), .SHIFT_BITS(SB)) u_big (
    .clk(clk), .reset(reset), .start(start_b), .modulus(mod_b), .offset(off_b),
    .busy(busy_b), .done(done_b),
`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
    .err(err_b),
`endif
    .wr(ifb.master)
  );

  always #5 clk = ~clk;

  logic          cur_valid, cur_busy, cur_done;
  logic [IB-1:0] cur_addr;
  logic [BW-1:0] cur_data;

  always_comb begin
    if (sel) begin
      cur_valid = ifb.wr_valid;
      cur_busy  = busy_b;
      cur_done  = done_b;
      cur_addr  = ifb.wr_addr;
      cur_data  = ifb.wr_data;
    end else begin
      cur_valid = ifs.wr_valid;
      cur_busy  = busy_s;
      cur_done  = done_s;
      cur_addr  = ifs.wr_addr;
      cur_data  = {{(BW-SW){1'b0}}, ifs.wr_data};
    end
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (low 256 bits)", name, act[255:0], exp[255:0]);
    end
  endtask

  // Monitor: compares every handshake against the queue and checks that a
  // stalled entry does not change.
  logic          stall = 1'b0;
  logic [IB-1:0] h_addr;
  logic [BW-1:0] h_data;
  exp_t          m_e;

  always @(negedge clk) begin
    if (reset || !cur_valid) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_addr", BW'(cur_addr), BW'(h_addr));
        check("hold_data", cur_data, h_data);
      end
      if (rdy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_write: got write at addr %0d want none", cur_addr);
        end else begin
          m_e = sb.pop_front();
          check("wr_addr", BW'(cur_addr), BW'(m_e.addr));
          check("wr_data", cur_data, m_e.data);
        end
        stall = 1'b0;
      end else begin
        stall  = 1'b1;
        h_addr = cur_addr;
        h_data = cur_data;
      end
    end
  end

  // Hand-computed table for N=13, offset=4 (base 3): entry k = 3k mod 13.
  task automatic push_hand13_off4();
    int   hv[13] = '{0, 3, 6, 9, 12, 2, 5, 8, 11, 1, 4, 7, 10};
    exp_t e;
    for (int kk = 0; kk < 32; kk++) begin
      e.addr = IB'(kk);
      e.data = BW'(hv[kk % 13]);
      sb.push_back(e);
    end
  endtask

  // N=13, offset=0: entry k = k mod 13.
  task automatic push_13_off0();
    exp_t e;
    for (int kk = 0; kk < 32; kk++) begin
      e.addr = IB'(kk);
      e.data = BW'(kk % 13);
      sb.push_back(e);
    end
  endtask

  // Wide bignum model: (k << off) mod n by direct division.
  task automatic push_model(input logic [BW-1:0] n, input int off);
    logic [MW-1:0] num, nn;
    exp_t          e;
    nn = MW'(n);
    for (int kk = 0; kk < 32; kk++) begin
      num    = MW'(kk) << off;
      e.addr = IB'(kk);
      e.data = BW'(num % nn);
      sb.push_back(e);
    end
  endtask

  // Issue a one-cycle start; returns #1 after the sampling edge (cycle 1).
  task automatic go(input bit big, input logic [BW-1:0] n, input int off);
    sel = big;
    if (big) begin
      mod_b   = n;
      off_b   = SB'(off);
      start_b = 1'b1;
    end else begin
      mod_s   = n[SW-1:0];
      off_s   = SB'(off);
      start_s = 1'b1;
    end
    @(posedge clk);
    #1;
    start_s = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int start_cyc, input int exp_cyc, input int bp_addr,
                           input logic [BW-1:0] bp_data);
    int cyc  = start_cyc;
    int hold = 0;
    while (!cur_done && cyc < 4000) begin
      if (bp_addr >= 0 && cur_valid && int'(cur_addr) == bp_addr && hold < 5) begin
        if (hold == 0) check("bp_data", cur_data, bp_data);
        rdy = 1'b0;
        hold++;
      end else begin
        rdy = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    rdy = 1'b1;
    check("done_cycle", BW'(cyc), BW'(exp_cyc));
    @(posedge clk);
    #1;
    check("done_pulse", BW'(cur_done), '0);
    check("busy_after", BW'(cur_busy), '0);
    check("sb_drained", BW'(sb.size()), '0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, BW'(busy_s), '0);
    check({tag, "_done"}, BW'(done_s), '0);
    check({tag, "_valid"}, BW'(ifs.wr_valid), '0);
    check({tag, "_addr"}, BW'(ifs.wr_addr), '0);
    check({tag, "_data"}, BW'(ifs.wr_data), '0);
  endtask

  logic [BW-1:0] nbig;

  initial begin
    reset   = 1'b1;
    rdy     = 1'b1;
    sel     = 1'b0;
    start_s = 1'b0;
    start_b = 1'b0;
    mod_s   = '0;
    mod_b   = '0;
    off_s   = '0;
    off_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    check("rst_big_busy", BW'(busy_b), '0);
    check("rst_big_valid", BW'(ifb.wr_valid), '0);
    check("rst_big_data", ifb.wr_data, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // N=13, offset=4, ready held high
    push_hand13_off4();
    go(1'b0, BW'(13), 4);
    check("busy_cycle1", BW'(busy_s), BW'(1));
    wait_done(1, 1 + 4 + 32, -1, '0);

    // N=13, offset=0
    push_13_off0();
    go(1'b0, BW'(13), 0);
    wait_done(1, 1 + 1 + 32, -1, '0);

    // Backpressure: 5 stalled cycles on addr 3 (value 9)
    push_hand13_off4();
    go(1'b0, BW'(13), 4);
    wait_done(1, 1 + 4 + 32 + 5, 3, BW'(9));

    // Reset while in POW
    go(1'b0, BW'(13), 4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_pow");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset in EMIT while addr 10 is presented
    begin
      int  cyc  = 1;
      bit  seen = 1'b0;
      push_hand13_off4();
      go(1'b0, BW'(13), 4);
      while (!(cur_valid && cur_addr == IB'(10)) && cyc < 200) begin
        if (cur_done) seen = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
      end
      check("abort_addr10_reached", BW'(cur_addr), BW'(10));
      check("abort_no_done", BW'(seen), '0);
      reset = 1'b1;
      #1;
      check_idle_outputs("rst_emit");
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
    end

    // Full regeneration after the aborts
    push_hand13_off4();
    go(1'b0, BW'(13), 4);
    wait_done(1, 1 + 4 + 32, -1, '0);

    // Start while busy with a different modulus and offset is ignored
    push_hand13_off4();
    go(1'b0, BW'(13), 4);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    mod_s   = 16'd11;
    off_s   = SB'(0);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    wait_done(4, 1 + 4 + 32, -1, '0);

    // N=1: every entry is 0
    push_model(BW'(1), 3);
    go(1'b0, BW'(1), 3);
    wait_done(1, 1 + 3 + 32, -1, '0);

    // Maximum offset with a large 16-bit odd modulus
    push_model(BW'(65521), 2047);
    go(1'b0, BW'(65521), 2047);
    wait_done(1, 1 + 2047 + 32, -1, '0);

`ifdef XPB_TABLE_GEN_RANGE_CHECK_EN
    // Even modulus is rejected with no writes; a later valid start clears err
    go(1'b0, BW'(12), 4);
    check("err_set", BW'(err_s), BW'(1));
    check("err_done", BW'(done_s), BW'(1));
    check("err_busy", BW'(busy_s), '0);
    @(posedge clk);
    #1;
    check("err_done_pulse", BW'(done_s), '0);
    check("err_held", BW'(err_s), BW'(1));
    push_13_off0();
    go(1'b0, BW'(13), 0);
    check("err_cleared", BW'(err_s), '0);
    wait_done(1, 1 + 1 + 32, -1, '0);
`endif

    // Wide random odd modulus, offset 600
    for (int i = 0; i < 32; i++) nbig[i*32 +: 32] = $urandom;
    nbig[0]    = 1'b1;
    nbig[BW-1] = 1'b1;
    push_model(nbig, 600);
    go(1'b1, nbig, 600);
    wait_done(1, 1 + 600 + 32, -1, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
